// File: rtl/spl_addr_seq.sv
// Round-robin address-burst scheduler: grants one of NUM_REQ requesters and streams
// its burst addresses through a single split-carry incrementer, one beat per two cycles.
module spl_addr_seq #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int LEN_WIDTH  = 16,
   parameter int ID_WIDTH   = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ADDR_WIDTH-1:0]           out_addr,
   output logic [ID_WIDTH-1:0]             out_id,
   output logic                            out_last,
   output logic                            busy
);

   localparam int HALF = ADDR_WIDTH / 2;

   typedef enum logic [1:0] {IDLE, LOAD, ISSUE, SETTLE} state_t;

   state_t                  state, state_nxt;
   logic [ID_WIDTH-1:0]     ptr;
   logic [ID_WIDTH-1:0]     id_q;
   logic [HALF-1:0]         addr_lo, addr_hi;
   logic [HALF:0]           lo_sum;
   logic [LEN_WIDTH-1:0]    rem;

   logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
   logic [LEN_WIDTH-1:0]    len_arr  [NUM_REQ];
   logic                    gnt_any;
   logic [ID_WIDTH-1:0]     gnt_idx;
   logic [ID_WIDTH-1:0]     scan_idx;
   logic                    take;
   logic                    step;
   logic [NUM_REQ-1:0]      ready_c;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         len_arr[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
   end

   // Rotating search starting just after the last winner.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (!gnt_any && req_valid[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt = state;
      ready_c   = '0;
      out_valid = 1'b0;
      take      = 1'b0;
      step      = 1'b0;
      unique case (state)
         IDLE: begin
            if (gnt_any) begin
               take             = 1'b1;
               ready_c[gnt_idx] = 1'b1;
               if (len_arr[gnt_idx] != '0) state_nxt = LOAD;
            end
         end
         LOAD:   state_nxt = ISSUE;
         ISSUE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (rem == LEN_WIDTH'(1)) begin
                  state_nxt = IDLE;
               end else begin
                  step      = 1'b1;
                  state_nxt = SETTLE;
               end
            end
         end
         SETTLE: state_nxt = ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= ID_WIDTH'(NUM_REQ - 1);
         id_q    <= '0;
         addr_lo <= '0;
         addr_hi <= '0;
         lo_sum  <= '0;
         rem     <= '0;
      end else begin
         state  <= state_nxt;
         // Low-half sum runs every cycle; it is only consumed after addr has been stable a cycle.
         lo_sum <= (HALF+1)'(addr_lo) + (HALF+1)'(1);
         if (take) begin
            ptr     <= gnt_idx;
            id_q    <= gnt_idx;
            addr_lo <= addr_arr[gnt_idx][HALF-1:0];
            addr_hi <= addr_arr[gnt_idx][ADDR_WIDTH-1:HALF];
            rem     <= len_arr[gnt_idx];
         end else if (step) begin
            addr_lo <= lo_sum[HALF-1:0];
            addr_hi <= addr_hi + HALF'(lo_sum[HALF]);
            rem     <= rem - LEN_WIDTH'(1);
         end
      end
   end

   // The grant is combinational, so mask it while reset is held to keep outputs at zero.
   assign req_ready = ready_c & {NUM_REQ{~reset}};
   assign out_addr  = {addr_hi, addr_lo};
   assign out_id    = id_q;
   assign out_last  = (state == ISSUE) && (rem == LEN_WIDTH'(1));
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spl_addr_seq.sv
// Self-checking bench for spl_addr_seq: a burst-level model predicts grants and beats,
// directed tests pin the model with literal addresses, orders and latencies.
module tb_spl_addr_seq;

   localparam int N  = 4;
   localparam int AW = 64;
   localparam int LW = 16;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*LW-1:0]   req_len;
   logic [N-1:0]      req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_addr;
   logic [IW-1:0]     out_id;
   logic              out_last;
   logic              busy;

   spl_addr_seq #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_id    (out_id),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      int            id;
      bit            last;
   } beat_t;

   int            n_cmp  = 0;
   int            n_fail = 0;
   int            cyc    = 0;

   beat_t         exp_q[$];
   int            mptr;
   int            wcnt;

   int            grant_log[$];
   int            grant_cyc[$];
   logic [AW-1:0] acc_addr[$];
   int            acc_cyc[$];
   bit            acc_last[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int next_grant(input logic [N-1:0] rv, input int p);
      for (int k = 1; k <= N; k++) begin
         if (rv[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Burst-level model: a granted burst becomes len expected beats, each appearing
   // two cycles after the previous grant or handshake and held until accepted.
   always @(negedge clk) begin
      int            g;
      int            len;
      logic [AW-1:0] base;
      if (reset) begin
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_flags", {61'd0, out_valid, out_last, busy}, 64'd0);
         check("rst_addr", out_addr, 64'd0);
         check("rst_id", 64'(out_id), 64'd0);
         exp_q.delete();
         mptr = N - 1;
         wcnt = 0;
      end else if (exp_q.size() == 0) begin
         check("busy_idle", 64'(busy), 64'd0);
         check("valid_idle", 64'(out_valid), 64'd0);
         if (req_valid != '0) begin
            g = next_grant(req_valid, mptr);
            check("req_ready", 64'(req_ready), 64'd1 << g);
            mptr = g;
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
            base = req_addr[g*AW +: AW];
            len  = int'(req_len[g*LW +: LW]);
            for (int i = 0; i < len; i++)
               exp_q.push_back('{addr: base + 64'(i), id: g, last: (i == len - 1)});
            wcnt = 2;
         end else begin
            check("req_ready_idle", 64'(req_ready), 64'd0);
         end
      end else begin
         check("busy", 64'(busy), 64'd1);
         check("req_ready_busy", 64'(req_ready), 64'd0);
         if (wcnt > 0) wcnt--;
         check("out_valid", 64'(out_valid), 64'(wcnt == 0));
         if (wcnt == 0) begin
            check("out_addr", out_addr, exp_q[0].addr);
            check("out_id", 64'(out_id), 64'(exp_q[0].id));
            check("out_last", 64'(out_last), 64'(exp_q[0].last));
            if (out_ready) begin
               acc_addr.push_back(out_addr);
               acc_cyc.push_back(cyc);
               acc_last.push_back(out_last);
               void'(exp_q.pop_front());
               wcnt = 2;
            end
         end
      end
   end

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      acc_addr.delete();
      acc_cyc.delete();
      acc_last.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_req(input int r, input logic [AW-1:0] a, input int l);
      req_addr[r*AW +: AW] = a;
      req_len[r*LW +: LW]  = LW'(l);
   endtask

   task automatic post(input int r, input logic [AW-1:0] a, input int l);
      set_req(r, a, l);
      req_valid = N'(1) << r;
   endtask

   task automatic wait_grants(input int n);
      int t = 0;
      while (grant_log.size() < n && t < 200) begin
         tick(1);
         t++;
      end
      check("grant_wait_timeout", 64'(grant_log.size() >= n), 64'd1);
   endtask

   task automatic wait_accepts(input int n);
      int t = 0;
      while (acc_addr.size() < n && t < 400) begin
         tick(1);
         t++;
      end
      check("accept_wait_timeout", 64'(acc_addr.size() >= n), 64'd1);
   endtask

   task automatic do_reset();
      tick(1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_len   = '0;
      out_ready = 1'b1;
      mptr      = N - 1;
      wcnt      = 0;
      tick(3);
      reset = 1'b0;
      tick(2);

      // 1: three beats from 0x1000, first beat two cycles after the grant
      clear_logs();
      post(0, 64'h1000, 3);
      wait_grants(1);
      req_valid = '0;
      wait_accepts(3);
      for (int k = 0; k < 3; k++) begin
         check("t1_addr", acc_addr[k], 64'h1000 + 64'(k));
         check("t1_latency", 64'(acc_cyc[k] - grant_cyc[0]), 64'(2 + 2*k));
         check("t1_last", 64'(acc_last[k]), 64'(k == 2));
      end
      tick(3);

      // 2: carry from the low half into the high half
      clear_logs();
      post(0, 64'h0000_0000_FFFF_FFFE, 3);
      wait_grants(1);
      req_valid = '0;
      wait_accepts(3);
      check("t2_beat0", acc_addr[0], 64'h0000_0000_FFFF_FFFE);
      check("t2_beat1", acc_addr[1], 64'h0000_0000_FFFF_FFFF);
      check("t2_beat2", acc_addr[2], 64'h0000_0001_0000_0000);
      tick(3);

      // 3: full wrap of the address space
      clear_logs();
      post(0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
      wait_grants(1);
      req_valid = '0;
      wait_accepts(2);
      check("t3_beat0", acc_addr[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("t3_beat1", acc_addr[1], 64'h0);
      check("t3_last0", 64'(acc_last[0]), 64'd0);
      check("t3_last1", 64'(acc_last[1]), 64'd1);
      tick(3);

      // 4: all requesters held, single-beat bursts rotate 0,1,2,3,0
      do_reset();
      clear_logs();
      for (int r = 0; r < N; r++) set_req(r, 64'h100 * 64'(r), 1);
      req_valid = '1;
      wait_grants(5);
      req_valid = '0;
      wait_accepts(5);
      tick(4);
      check("t4_grants", 64'(grant_log.size()), 64'd5);
      check("t4_g0", 64'(grant_log[0]), 64'd0);
      check("t4_g1", 64'(grant_log[1]), 64'd1);
      check("t4_g2", 64'(grant_log[2]), 64'd2);
      check("t4_g3", 64'(grant_log[3]), 64'd3);
      check("t4_g4", 64'(grant_log[4]), 64'd0);
      check("t4_beat2", acc_addr[2], 64'h200);

      // 5: stall on beat 2 keeps everything stable, four beats total
      clear_logs();
      post(2, 64'h3000, 4);
      wait_grants(1);
      req_valid = '0;
      wait_accepts(1);
      out_ready = 1'b0;
      tick(6);
      out_ready = 1'b1;
      wait_accepts(4);
      tick(6);
      check("t5_count", 64'(acc_addr.size()), 64'd4);
      for (int k = 0; k < 4; k++)
         check("t5_addr", acc_addr[k], 64'h3000 + 64'(k));

      // zero-length request: accept pulse only, no beats
      clear_logs();
      post(3, 64'h4000, 0);
      wait_grants(1);
      req_valid = '0;
      tick(6);
      check("len0_grant", 64'(grant_log[0]), 64'd3);
      check("len0_beats", 64'(acc_addr.size()), 64'd0);

      // 6: reset during SETTLE aborts the burst; requester 0 wins afterwards
      clear_logs();
      post(1, 64'h2000, 8);
      wait_grants(1);
      req_valid = '0;
      wait_accepts(2);
      reset = 1'b1;
      set_req(0, 64'h5000, 1);
      set_req(3, 64'h6000, 1);
      req_valid = 4'b1011;
      tick(1);
      reset = 1'b0;
      clear_logs();
      wait_grants(1);
      req_valid = '0;
      wait_accepts(1);
      tick(4);
      check("t6_first_grant", 64'(grant_log[0]), 64'd0);
      check("t6_beat", acc_addr[0], 64'h5000);
      check("t6_count", 64'(acc_addr.size()), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
